adc_spi_rx: RTL and testbench
=============================

Name: adc_spi_rx

Overview:
- Upstream acquisition stage: periodically reads one 12-bit sample from a serial ADC (AD7476-class: CS-framed, 16 SCLK, 4 leading zeros, then 12 bits MSB first).
- Converts the offset-binary code to a signed fixed-point word of width CANT_BITS.
- Presents the word to the filter stage with a one-cycle valid strobe.
- Owns the sample-rate timebase for the whole audio chain.

Parameters:
- CANT_BITS, 25, width of the output word; same width the filter consumes.
- FRAC_BITS, 12, fractional bits of the output format; ADC full scale maps to ±1.0. Must be ≥11.
- SCLK_DIV, 4, system clocks per SCLK half-period (100 MHz / 8 = 12.5 MHz SCLK).
- FS_DIV, 2268, system clocks per sample period (≈44.1 kHz at 100 MHz). Must satisfy FS_DIV ≥ 32*SCLK_DIV + 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sdata  in  1  ADC serial data
- cs  out  1  ADC chip select, active low
- sclk  out  1  ADC serial clock, idles high
- desp_enable  out  1  one-cycle strobe: new dato_final valid
- dato_final  out  CANT_BITS  signed two's-complement sample, FRAC_BITS fractional bits

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: cs=1, sclk=1, desp_enable=0, dato_final=0. All counters and the shift register clear; FSM goes to IDLE.
- Rate counter:
  - Free-runs 0..FS_DIV-1 and wraps.
  - A tick is the cycle where count==FS_DIV-1.
  - The first tick after reset occurs FS_DIV cycles after reset release.
- FSM states: IDLE, CONV, DONE.
  - IDLE: cs=1, sclk=1. A tick moves to CONV on the next cycle (cycle T+1 for a tick at T).
  - CONV:
    - cs=0. Divider counts 0..SCLK_DIV-1.
    - On the terminal count sclk toggles; the first toggle is a falling edge.
    - In the cycle sclk is driven 0→1, shift register <= {shift[14:0], sdata}, and the edge counter increments.
    - After the 16th rising edge (32nd toggle, at T+1+32*SCLK_DIV), the FSM moves to DONE.
  - DONE (1 cycle):
    - cs=1, sclk=1.
    - dato_final <= sign_extend({~s[11], s[10:0]}) << (FRAC_BITS-11), where s = shift[11:0]. shift[15:12] is ignored.
    - desp_enable=1 in this cycle only. Next state IDLE.
- Latency: tick at T → desp_enable high and dato_final updated at cycle T+2+32*SCLK_DIV (T+130 at defaults).
- dato_final holds its value between strobes. desp_enable is never high for two consecutive cycles.
- A tick arriving outside IDLE is ignored; the parameter constraint prevents this. The rate counter is never stalled or reset by the FSM.
- Reset mid-frame: cs and sclk return high immediately (asynchronously). The partial sample is discarded and no strobe is issued.
- Arithmetic: the shift amount is constant. Results range from -2048·2^(FRAC_BITS-11) to +2047·2^(FRAC_BITS-11), with no overflow for CANT_BITS ≥ FRAC_BITS+2.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/CONV/DONE).
  - Frame constants: ADC_FRAME_BITS=16, ADC_DATA_BITS=12, ADC_LEAD_ZEROS=4.
  - Default CANT_BITS/FRAC_BITS, for reuse by the filter and truncator.
- One natural sub-module: adc_rate_tick (FS_DIV wrap counter with tick output). Divider, shift register and FSM stay in this block.

Test Plan:
- Reset values: assert rst mid-idle → cs=1, sclk=1, desp_enable=0, dato_final=0. First cs fall occurs at FS_DIV+1 cycles after release.
- Frame timing (defaults), per frame:
  - cs low for exactly 128 cycles.
  - 16 sclk rising edges, sclk period 8 cycles.
  - desp_enable exactly one cycle, at tick+130.
  - Strobes spaced 2268 cycles apart.
- Mid-scale: ADC model drives 0000_1000_0000_0000 → dato_final = 0x0000000.
- Positive full scale: ADC model drives 0x0FFF → dato_final = +4094 = 0x0000FFE.
- Negative full scale: ADC model drives 0x0000 → dato_final = -4096 = 0x1FFF000. Leading bits set to 1111 in the model must not change the result.
- Reset during CONV (after 7 rising edges) → cs/sclk high immediately, no strobe, dato_final keeps its previous value (0 after reset). The next frame captures correctly.

Source files
------------

// File: rtl/adc_spi_rx_pkg.sv
// Shared definitions for the ADC acquisition front end: FSM encoding, frame layout and
// the default fixed-point format that the downstream filter and truncator also use.
package adc_spi_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } adc_state_e;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;
  localparam int unsigned ADC_LEAD_ZEROS = 4;

  localparam int unsigned DEFAULT_CANT_BITS = 25;
  localparam int unsigned DEFAULT_FRAC_BITS = 12;

  // Offset-binary to two's complement: flipping the MSB re-centres mid-scale on zero.
  function automatic logic signed [ADC_DATA_BITS-1:0] offset_to_signed(
    input logic [ADC_DATA_BITS-1:0] code
  );
    return {~code[ADC_DATA_BITS-1], code[ADC_DATA_BITS-2:0]};
  endfunction

endpackage

// File: rtl/adc_rate_tick.sv
// Free-running sample-rate timebase: counts 0..FS_DIV-1 and flags the terminal count.
module adc_rate_tick #(
  parameter int unsigned FS_DIV = 2268
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FS_DIV - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick = (count_q == CntLast);

  always_comb begin
    count_d = count_q + 1'b1;
    if (tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adc_spi_rx.sv
// Serial ADC reader: frames one 16-SCLK conversion per rate tick and emits the sample as a
// signed fixed-point word with a single-cycle valid strobe.
module adc_spi_rx
  import adc_spi_rx_pkg::*;
#(
  parameter int unsigned CANT_BITS = DEFAULT_CANT_BITS,
  parameter int unsigned FRAC_BITS = DEFAULT_FRAC_BITS,
  parameter int unsigned SCLK_DIV  = 4,
  parameter int unsigned FS_DIV    = 2268
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdata,
  output logic                 cs,
  output logic                 sclk,
  output logic                 desp_enable,
  output logic [CANT_BITS-1:0] dato_final
);

  localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);
  localparam logic [4:0] EdgeLast = 5'(ADC_FRAME_BITS - 1);
  localparam int unsigned FracShift = FRAC_BITS - 11;

  adc_state_e state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [4:0] edge_q, edge_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic sclk_q, sclk_d;
  logic desp_q, desp_d;
  logic [CANT_BITS-1:0] dato_q, dato_d;
  logic tick;
  logic signed [CANT_BITS-1:0] sample_ext;

  adc_rate_tick #(
    .FS_DIV(FS_DIV)
  ) u_rate_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // The leading-zero nibble is clocked in but never used.
  logic unused_lead;
  assign unused_lead = ^shift_q[ADC_FRAME_BITS-1:ADC_DATA_BITS];

  assign sample_ext = CANT_BITS'(offset_to_signed(shift_q[ADC_DATA_BITS-1:0]));

  // cs is decoded from state so an asynchronous reset raises it immediately.
  assign cs          = (state_q != StConv);
  assign sclk        = sclk_q;
  assign desp_enable = desp_q;
  assign dato_final  = dato_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    desp_d  = 1'b0;
    dato_d  = dato_q;

    unique case (state_q)
      StIdle: begin
        sclk_d = 1'b1;
        div_d  = '0;
        edge_d = '0;
        if (tick) begin
          state_d = StConv;
        end
      end
      StConv: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Sample on the cycle that drives sclk high; the ADC updated sdata on the fall.
          if (!sclk_q) begin
            shift_d = {shift_q[ADC_FRAME_BITS-2:0], sdata};
            edge_d  = edge_q + 5'd1;
            if (edge_q == EdgeLast) begin
              state_d = StDone;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        sclk_d  = 1'b1;
        desp_d  = 1'b1;
        dato_d  = sample_ext <<< FracShift;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      desp_q  <= 1'b0;
      dato_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      desp_q  <= desp_d;
      dato_q  <= dato_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_rx.sv
// Directed bench for adc_spi_rx: behavioural ADC model, frame timing checks and
// hand-computed sample values, including reset in idle and mid-conversion.
module tb_adc_spi_rx;

  localparam int CANT_BITS = 25;
  localparam int FRAC_BITS = 12;
  localparam int SCLK_DIV  = 4;
  localparam int FS_DIV    = 2268;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sdata;
  logic                 cs;
  logic                 sclk;
  logic                 desp_enable;
  logic [CANT_BITS-1:0] dato_final;

  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  int          prev_strobe = -1;
  int          bit_idx = 0;
  logic [15:0] adc_word = 16'h0000;

  adc_spi_rx #(
    .CANT_BITS(CANT_BITS),
    .FRAC_BITS(FRAC_BITS),
    .SCLK_DIV (SCLK_DIV),
    .FS_DIV   (FS_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sdata      (sdata),
    .cs         (cs),
    .sclk       (sclk),
    .desp_enable(desp_enable),
    .dato_final (dato_final)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: frame bit j is presented after the (j+1)-th sclk fall of the frame.
  always @(negedge sclk or posedge cs) begin
    if (cs) begin
      bit_idx <= 0;
      sdata   <= 1'b0;
    end else begin
      sdata   <= adc_word[15 - bit_idx];
      bit_idx <= bit_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"}, 32'(cs), 32'd1);
    check({tag, "_sclk"}, 32'(sclk), 32'd1);
    check({tag, "_desp"}, 32'(desp_enable), 32'd0);
    check({tag, "_dato"}, 32'(dato_final), 32'd0);
  endtask

  // Releases reset on a falling clock edge and counts rising edges until cs goes low.
  task automatic release_and_time_first_fall(input string tag);
    int n = 0;
    int strobes = 0;
    @(negedge clk);
    rst = 1'b0;
    while (n < FS_DIV + 100) begin
      @(negedge clk);
      n++;
      if (desp_enable) strobes++;
      if (!cs) break;
    end
    check({tag, "_first_cs_fall_edges"}, 32'(n), 32'(FS_DIV));
    check({tag, "_no_strobe"}, 32'(strobes), 32'd0);
    check({tag, "_dato_held"}, 32'(dato_final), 32'd0);
    prev_strobe = -1;
  endtask

  task automatic frame(input logic [15:0] word, input logic [CANT_BITS-1:0] exp,
                       input string tag);
    int   n = 0;
    int   t_fall;
    int   low = 0;
    int   rises = 0;
    int   last_rise = -1;
    int   bad_period = 0;
    int   strobes = 0;
    int   strobe_at = -1;
    logic low_done = 1'b0;
    logic prev_sclk;
    logic [CANT_BITS-1:0] at_strobe = '0;
    adc_word = word;
    while (cs && n < FS_DIV + 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cs_fell"}, 32'(cs), 32'd0);
    t_fall    = cyc;
    prev_sclk = sclk;
    for (int i = 0; i < 200; i++) begin
      if (!cs && !low_done) low++;
      else low_done = 1'b1;
      if (sclk && !prev_sclk) begin
        if (last_rise >= 0 && cyc - last_rise != 2 * SCLK_DIV) bad_period++;
        last_rise = cyc;
        rises++;
      end
      prev_sclk = sclk;
      if (desp_enable) begin
        strobes++;
        if (strobe_at < 0) begin
          strobe_at = cyc;
          at_strobe = dato_final;
        end
      end
      @(negedge clk);
    end
    check({tag, "_cs_low_cycles"}, 32'(low), 32'd128);
    check({tag, "_sclk_rises"}, 32'(rises), 32'd16);
    check({tag, "_sclk_period_errors"}, 32'(bad_period), 32'd0);
    check({tag, "_strobe_cycles"}, 32'(strobes), 32'd1);
    check({tag, "_tick_to_strobe"}, 32'(strobe_at - (t_fall - 1)), 32'd130);
    check({tag, "_dato_at_strobe"}, 32'(at_strobe), 32'(exp));
    check({tag, "_dato_held"}, 32'(dato_final), 32'(exp));
    if (prev_strobe >= 0) begin
      check({tag, "_strobe_spacing"}, 32'(strobe_at - prev_strobe), 32'(FS_DIV));
    end
    prev_strobe = strobe_at;
  endtask

  initial begin
    int n;
    int rises;
    logic prev_sclk;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_and_time_first_fall("por");

    frame(16'h0800, 25'h0000000, "mid_scale");
    frame(16'h0FFF, 25'h0000FFE, "pos_full");
    frame(16'h0000, 25'h1FFF000, "neg_full");
    frame(16'hF000, 25'h1FFF000, "neg_full_lead_ones");
    frame(16'h0ABC, 25'h0000578, "mixed");

    // Reset while idle with a non-zero sample held.
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("idle_rst");
    release_and_time_first_fall("idle_rst");
    frame(16'h0123, 25'h1FFF246, "after_idle_rst");

    // Reset in the middle of a conversion, after 7 sclk rising edges, with sclk low.
    adc_word = 16'h0FFF;
    n = 0;
    while (cs && n < FS_DIV + 100) begin
      @(negedge clk);
      n++;
    end
    rises     = 0;
    n         = 0;
    prev_sclk = sclk;
    while (rises < 7 && n < 200) begin
      @(negedge clk);
      n++;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
    end
    check("conv_rst_rises_before_reset", 32'(rises), 32'd7);
    n = 0;
    while (sclk && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("conv_rst_cs_low_before_reset", 32'(cs), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("conv_rst");
    release_and_time_first_fall("conv_rst");
    frame(16'h0123, 25'h1FFF246, "after_conv_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
